// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native bus: m0 (CPU) and m1 (DMA) share one slave port.
// Define ARB_TIMEOUT_EN to add a watchdog that force-completes transactions the slave never acknowledges.
module mem_bus_arbiter #(
    parameter int unsigned   AW             = 32,
    parameter int unsigned   DW             = 32,
    parameter int unsigned   TIMEOUT_CYCLES = 255,
    parameter logic [DW-1:0] TIMEOUT_RDATA  = DW'(32'hDEADBEEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_valid,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_ready,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_valid,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_ready,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_valid,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_ready,
    input  logic [DW-1:0]   s_rdata,
    output logic [1:0]      grant,
    output logic            timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic        last_q;      // 1 = m1 was served most recently

    logic [1:0]  m_valid;
    logic        busy;
    logic        gnt_valid;
    logic        to_hit;
    logic        done;
    logic        abort;
    logic [DW-1:0] resp_rdata;
    logic [1:0]  m_ready;
    logic [DW-1:0] m_rdata [2];

    assign m_valid   = {m1_valid, m0_valid};
    assign busy      = (state_q == BUSY);
    assign gnt_valid = |(grant_q & m_valid);
    assign done      = busy & gnt_valid & (s_ready | to_hit);
    assign abort     = busy & ~gnt_valid;
    assign grant     = grant_q;

    always_comb begin
        s_valid = busy;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (busy) begin
            if (grant_q[1]) begin
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end else begin
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign m_ready[gi] = done & grant_q[gi];
            assign m_rdata[gi] = m_ready[gi] ? resp_rdata : '0;
        end
    endgenerate

    assign m0_ready = m_ready[0];
    assign m1_ready = m_ready[1];
    assign m0_rdata = m_rdata[0];
    assign m1_rdata = m_rdata[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // On a tie the master that was not served last wins.
                    if (m0_valid && (!m1_valid || last_q)) begin
                        grant_q <= 2'b01;
                        state_q <= BUSY;
                    end else if (m1_valid) begin
                        grant_q <= 2'b10;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end else if (done) begin
                        last_q  <= grant_q[1];
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q <= 2'b00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        timeout_err_q;
    logic        timeout_err_d;

    // Fires in BUSY cycle number TIMEOUT_CYCLES; a real s_ready in that cycle still wins.
    assign to_hit     = busy & ~s_ready & (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign resp_rdata = s_ready ? s_rdata : TIMEOUT_RDATA;

    always_comb begin
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (!s_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (to_hit && gnt_valid) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_cfg;

    assign to_hit      = 1'b0;
    assign resp_rdata  = s_rdata;
    assign timeout_err = 1'b0;
    assign unused_cfg  = ^{TIMEOUT_RDATA, 16'(TIMEOUT_CYCLES)};
`endif

endmodule
